// File: rtl/memory_controller_pkg.sv
// Shared types and constants for the serial-SRAM memory controller.
// MEM_SPI_CLK_DIV4_EN selects 4 clocks per SPI bit instead of 2.
package memory_controller_pkg;

  typedef enum logic [2:0] {
    STATE_RESET,
    STATE_FETCH,
    STATE_DECODE,
    STATE_EXECUTE,
    STATE_LOAD_MEM,
    STATE_STORE_MEM,
    STATE_WRITEBACK,
    STATE_HALT
  } sys_state_t;

  typedef enum logic [2:0] {
    MC_IDLE,
    MC_CMD,
    MC_ADDR,
    MC_DATA,
    MC_DONE
  } mc_state_t;

  typedef enum logic [1:0] {
    OP_FETCH,
    OP_LOAD,
    OP_STORE
  } mem_op_t;

  localparam logic [7:0] MEM_CMD_READ  = 8'h03;
  localparam logic [7:0] MEM_CMD_WRITE = 8'h02;

  localparam int MEM_CMD_BITS   = 8;
  localparam int MEM_ADDR_BITS  = 16;
  localparam int MEM_FETCH_BITS = 16;
  localparam int MEM_BYTE_BITS  = 8;
  localparam int MEM_BIT_CNT_W  = 4;

`ifdef MEM_SPI_CLK_DIV4_EN
  localparam int MEM_PHASE_W = 2;
`else
  localparam int MEM_PHASE_W = 1;
`endif

  function automatic logic [MEM_BIT_CNT_W-1:0] last_bit(input int n);
    return MEM_BIT_CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/spi_bit_engine.sv
// SPI mode-0 bit engine: SCK phase generation, MOSI shift-out, MISO shift-in.
// Phase width comes from the package (MEM_SPI_CLK_DIV4_EN widens it).
module spi_bit_engine
  import memory_controller_pkg::*;
(
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        active_in,
  input  logic        load_in,
  input  logic [15:0] load_data_in,
  input  logic        miso_in,
  output logic        sck_out,
  output logic        mosi_out,
  output logic        bit_end_out,
  output logic [15:0] rx_next_out
);

  logic [MEM_PHASE_W-1:0] phase_q, phase_d;
  logic [15:0]            tx_q, tx_d;
  logic [15:0]            rx_q, rx_d;

  assign bit_end_out = active_in && (phase_q == '1);
  assign sck_out     = active_in && phase_q[MEM_PHASE_W-1];
  assign mosi_out    = active_in && tx_q[15];
  assign rx_next_out = {rx_q[14:0], miso_in};

  always_comb begin
    phase_d = active_in ? phase_q + 1'b1 : '0;
    tx_d    = tx_q;
    rx_d    = rx_q;
    if (bit_end_out) begin
      tx_d = {tx_q[14:0], 1'b0};
      rx_d = rx_next_out;
    end
    // A new segment reloads the shifter on the same edge the old one ends
    if (load_in) begin
      tx_d = load_data_in;
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      phase_q <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
    end else begin
      phase_q <= phase_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
    end
  end

endmodule

// File: rtl/memory_controller.sv
// Serial SRAM controller: fetch (2 bytes), load (1 byte), store (1 byte).
// MEM_SPI_CLK_DIV4_EN halves the SPI bit rate (see package).
module memory_controller
  import memory_controller_pkg::*;
(
  input  logic        clk_in,
  input  logic        reset_in,
  input  sys_state_t  seq_state_in,
  input  logic [15:0] pc_in,
  input  logic [15:0] data_addr_in,
  input  logic [7:0]  store_data_in,
  output logic        mem_busy_out,
  output logic        inst_fetch_done_out,
  output logic        data_read_done_out,
  output logic [15:0] inst_out,
  output logic [7:0]  data_out,
  output logic        spi_cs_n_out,
  output logic        spi_sck_out,
  output logic        spi_mosi_out,
  input  logic        spi_miso_in
);

  mc_state_t                state_q, state_d;
  mem_op_t                  op_q, op_d;
  logic [MEM_BIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]              addr_q, addr_d;
  logic [7:0]               wdata_q, wdata_d;
  logic [15:0]              inst_q, inst_d;
  logic [7:0]               data_q, data_d;

  logic        busy;
  logic        load;
  logic [15:0] load_data;
  logic        bit_end;
  logic [15:0] rx_next;

  assign busy = (state_q == MC_CMD) || (state_q == MC_ADDR) ||
                (state_q == MC_DATA);

  spi_bit_engine u_engine (
    .clk_in       (clk_in),
    .reset_in     (reset_in),
    .active_in    (busy),
    .load_in      (load),
    .load_data_in (load_data),
    .miso_in      (spi_miso_in),
    .sck_out      (spi_sck_out),
    .mosi_out     (spi_mosi_out),
    .bit_end_out  (bit_end),
    .rx_next_out  (rx_next)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    inst_d    = inst_q;
    data_d    = data_q;
    load      = 1'b0;
    load_data = '0;
    unique case (state_q)
      MC_IDLE: begin
        unique case (seq_state_in)
          STATE_FETCH: begin
            op_d   = OP_FETCH;
            addr_d = pc_in;
          end
          STATE_LOAD_MEM: begin
            op_d   = OP_LOAD;
            addr_d = data_addr_in;
          end
          STATE_STORE_MEM: begin
            op_d   = OP_STORE;
            addr_d = data_addr_in;
          end
          default: ;
        endcase
        if (seq_state_in == STATE_FETCH ||
            seq_state_in == STATE_LOAD_MEM ||
            seq_state_in == STATE_STORE_MEM) begin
          wdata_d   = store_data_in;
          state_d   = MC_CMD;
          cnt_d     = last_bit(MEM_CMD_BITS);
          load      = 1'b1;
          load_data = {(seq_state_in == STATE_STORE_MEM) ?
                       MEM_CMD_WRITE : MEM_CMD_READ, 8'h00};
        end
      end
      MC_CMD: begin
        if (bit_end) begin
          if (cnt_q == '0) begin
            state_d   = MC_ADDR;
            cnt_d     = last_bit(MEM_ADDR_BITS);
            load      = 1'b1;
            load_data = addr_q;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      MC_ADDR: begin
        if (bit_end) begin
          if (cnt_q == '0) begin
            state_d   = MC_DATA;
            cnt_d     = (op_q == OP_FETCH) ? last_bit(MEM_FETCH_BITS)
                                           : last_bit(MEM_BYTE_BITS);
            load      = 1'b1;
            // Reads keep MOSI low through the data phase
            load_data = (op_q == OP_STORE) ? {wdata_q, 8'h00} : 16'h0000;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      MC_DATA: begin
        if (bit_end) begin
          if (cnt_q == '0) begin
            state_d = MC_DONE;
            if (op_q == OP_FETCH) inst_d = rx_next;
            if (op_q == OP_LOAD)  data_d = rx_next[7:0];
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      MC_DONE: state_d = MC_IDLE;
      default: state_d = MC_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= MC_IDLE;
      op_q    <= OP_FETCH;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      inst_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      inst_q  <= inst_d;
      data_q  <= data_d;
    end
  end

  assign mem_busy_out        = busy;
  assign spi_cs_n_out        = !busy;
  assign inst_fetch_done_out = (state_q == MC_DONE) && (op_q == OP_FETCH);
  assign data_read_done_out  = (state_q == MC_DONE) && (op_q == OP_LOAD);
  assign inst_out            = inst_q;
  assign data_out            = data_q;

endmodule
